mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the Y86-64 pipeline.
- Consumes the M pipeline register that the execute stage drives (M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM).
- Performs data-memory reads and writes over a req/ack handshake, stalling upstream while an access is outstanding.
- Loads the W pipeline register for writeback, handles address errors, timeouts and pipeline halt.

Parameters:
- MEM_BYTES, 4096, size of legal data address space; an access is legal iff addr+7 < MEM_BYTES.
- TIMEOUT, 16, maximum WAIT cycles without dmem_ack before the access is declared an address error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- M_stat  in  3  status from execute (1 AOK, 2 HLT, 3 ADR, 4 INS).
- M_icode  in  4  instruction code.
- M_cnd  in  1  condition flag (passed through).
- M_valE  in  64  ALU result.
- M_valA  in  64  operand A / return address.
- M_dstE  in  4  E destination register (F = none).
- M_dstM  in  4  M destination register (F = none).
- m_stall  out  1  hold M register upstream (combinational).
- m_valM  out  64  forwarded read data, valid when dmem_ack in WAIT on a read, else 0.
- m_stat  out  3  forwarded status of the instruction currently in this stage.
- dmem_req  out  1  memory request (registered).
- dmem_we  out  1  write enable (registered).
- dmem_addr  out  64  byte address (registered).
- dmem_wdata  out  64  write data (registered).
- dmem_ack  in  1  access complete this cycle.
- dmem_rdata  in  64  read data, valid with ack.
- W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  3/4/64/64/4/4  writeback register.
- halted  out  1  pipeline halted.

Behaviour:
Reset:
- State IDLE; dmem_req/we = 0; dmem_addr/wdata = 0.
- W_stat = 1, W_icode = 1 (nop), W_valE = W_valM = 0, W_dstE = W_dstM = F.
- halted = 0; timeout counter = 0.
- Reset mid-access drops dmem_req immediately; no W update from that access.

Decode:
- Reads: icode 5 mrmovq, B popq, 9 ret.
- Writes: icode 4 rmmovq, A pushq, 8 call.
- Address: M_valE for 4, 5, A, 8; M_valA for B, 9.
- Write data: M_valA.
- Memop = read or write, and M_stat == AOK.

FSM:
- IDLE, not memop:
  - W loads M fields next edge (W_valM = 0).
  - m_stall = 0.
  - Latency 1 cycle.
- IDLE, memop with illegal address:
  - No request issued.
  - W loads with W_stat = 3 (ADR), W_dstM = F; next state HALT.
- IDLE, memop with legal address:
  - m_stall = 1.
  - Next edge: dmem_req = 1, dmem_we/addr/wdata latched, state WAIT, counter cleared.
- WAIT:
  - dmem_req/we/addr/wdata stable until ack.
  - m_stall = !dmem_ack.
  - Counter increments each cycle without ack.
- WAIT with dmem_ack:
  - W loads M fields; W_valM = dmem_rdata for reads, 0 for writes.
  - dmem_req drops next edge; state IDLE.
  - Minimum memop occupancy is 2 cycles.
- WAIT with counter == TIMEOUT-1 and no ack:
  - Request dropped; W loads with W_stat = 3; state HALT.
  - An ack arriving in the same cycle wins over the timeout.
- Non-AOK M_stat in IDLE:
  - No memory access.
  - W loads the status unchanged; state HALT next edge.
- HALT:
  - halted = 1; W frozen; no requests; m_stall = 1.
  - Only exit is reset.
- m_stat = ADR while IDLE with an illegal address, else M_stat.
- Address legality check is done in 65 bits so that addr+7 cannot wrap.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (NOP, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ, ...);
  - stat codes AOK/HLT/ADR/INS;
  - REG_NONE = F.
- One sub-module, mem_ctrl_fsm: the state register, timeout counter and dmem_* registers.
- Top level holds decode, address/legality muxing and the W register.

Test Plan:
- OPq, icode 6, M_valE = 0x2A, M_dstE = 3 → next edge W_valE = 0x2A, W_dstE = 3, m_stall never high, dmem_req never high.
- mrmovq, M_valE = 0x100, memory acks 3 cycles after req with rdata 0xDEADBEEF → m_stall high 4 cycles, dmem_we = 0, dmem_addr = 0x100, W_valM = 0xDEADBEEF on the ack edge.
- pushq, M_valE = 0xFF8, M_valA = 0x55, immediate ack → dmem_we = 1, addr 0xFF8, wdata 0x55, one cycle of WAIT.
- rmmovq to address 0xFFC with MEM_BYTES = 4096 → no dmem_req, W_stat = 3, halted = 1 next cycle, later inputs ignored.
- popq with no ack for 16 WAIT cycles → W_stat = 3 on the 16th WAIT edge, dmem_req low afterwards, halted = 1.
- rst_n pulled low during WAIT of a call → dmem_req drops asynchronously, all W outputs at reset values; after release a nop passes normally.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the memory stage: instruction codes, status
// codes, the "no register" id and the memory-controller state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_HALT = 2'd2
    } mem_state_t;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

    // pop and ret address through the stack pointer carried in valA
    function automatic logic uses_val_a_addr(input logic [3:0] icode);
        return (icode == I_POPQ) || (icode == I_RET);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the
// data memory (slave).
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ack;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_ctrl_fsm.sv
// Memory-access controller: state register, timeout counter and the
// registered dmem request outputs.
module mem_ctrl_fsm
    import y86_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        fail,
    input  logic        write,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    mem_stage_if.master dmem,
    output mem_state_t  state,
    output logic        timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             req_next;
    logic             we_next;
    logic [63:0]      addr_next;
    logic [63:0]      wdata_next;

    // an ack in the final allowed cycle takes priority over the timeout
    assign timeout = (state == MEM_WAIT) && !dmem.ack &&
                     (count == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        count_next = count;
        req_next   = dmem.req;
        we_next    = dmem.we;
        addr_next  = dmem.addr;
        wdata_next = dmem.wdata;
        case (state)
            MEM_IDLE: begin
                if (fail) begin
                    state_next = MEM_HALT;
                end else if (start) begin
                    state_next = MEM_WAIT;
                    req_next   = 1'b1;
                    we_next    = write;
                    addr_next  = addr;
                    wdata_next = wdata;
                    count_next = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem.ack) begin
                    state_next = MEM_IDLE;
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                end else if (timeout) begin
                    state_next = MEM_HALT;
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = MEM_HALT;
                req_next   = 1'b0;
                we_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MEM_IDLE;
            count      <= '0;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            dmem.req   <= req_next;
            dmem.we    <= we_next;
            dmem.addr  <= addr_next;
            dmem.wdata <= wdata_next;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: decodes the M register, runs data accesses through
// mem_ctrl_fsm and loads the W register for writeback.
module mem_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    output logic        m_stall,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    mem_stage_if.master dmem,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic        halted
);

    mem_state_t  state;
    logic        timeout;
    logic        rd;
    logic        wr;
    logic        memop;
    logic [63:0] mem_addr;
    logic [64:0] addr_last;
    logic        legal;
    logic        in_idle;
    logic        in_wait;
    logic        bad_addr;
    logic        start;
    logic        fail;
    logic        w_load;
    logic        unused_cnd;

    assign unused_cnd = M_cnd;

    assign rd       = is_mem_read(M_icode);
    assign wr       = is_mem_write(M_icode);
    assign memop    = (rd || wr) && (M_stat == S_AOK);
    assign mem_addr = uses_val_a_addr(M_icode) ? M_valA : M_valE;

    // 65-bit sum so an address near 2^64 cannot wrap into the legal range
    assign addr_last = {1'b0, mem_addr} + 65'd7;
    assign legal     = addr_last < 65'(MEM_BYTES);

    assign in_idle  = (state == MEM_IDLE);
    assign in_wait  = (state == MEM_WAIT);
    assign bad_addr = in_idle && memop && !legal;
    assign start    = in_idle && memop && legal;
    assign fail     = in_idle && ((M_stat != S_AOK) || bad_addr);

    assign m_stall = (state == MEM_HALT) || start || (in_wait && !dmem.ack);
    assign m_valM  = (in_wait && dmem.ack && rd) ? dmem.rdata : 64'd0;
    assign m_stat  = bad_addr ? S_ADR : M_stat;
    assign halted  = (state == MEM_HALT);
    assign w_load  = (in_idle && !start) || (in_wait && (dmem.ack || timeout));

    mem_ctrl_fsm #(.TIMEOUT(TIMEOUT)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .fail    (fail),
        .write   (wr),
        .addr    (mem_addr),
        .wdata   (M_valA),
        .dmem    (dmem),
        .state   (state),
        .timeout (timeout)
    );

    // W register; a timed-out access is reported as an address error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_stat  <= S_AOK;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= REG_NONE;
            W_dstM  <= REG_NONE;
        end else if (w_load) begin
            W_stat  <= timeout ? S_ADR : m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= bad_addr ? REG_NONE : M_dstM;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written multi-cycle
// sequences and randomized transactions against a rule-level model.
module tb_mem_stage;

    localparam int MEM_BYTES = 4096;
    localparam int TIMEOUT   = 16;

    logic        clk;
    logic        rst_n;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        m_stall;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        halted;

    int checks = 0;
    int errors = 0;

    mem_stage_if dmem ();

    mem_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .M_stat  (M_stat),
        .M_icode (M_icode),
        .M_cnd   (M_cnd),
        .M_valE  (M_valE),
        .M_valA  (M_valA),
        .M_dstE  (M_dstE),
        .M_dstM  (M_dstM),
        .m_stall (m_stall),
        .m_valM  (m_valM),
        .m_stat  (m_stat),
        .dmem    (dmem),
        .W_stat  (W_stat),
        .W_icode (W_icode),
        .W_valE  (W_valE),
        .W_valM  (W_valM),
        .W_dstE  (W_dstE),
        .W_dstM  (W_dstM),
        .halted  (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic        exp_stall;
        logic [2:0]  exp_mstat;
        logic [2:0]  exp_wstat;
        logic [3:0]  exp_wdstm;
        logic        exp_halt;
    } vec_t;

    typedef struct {
        int          stall_cnt;
        int          wait_cnt;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] valm;
        logic        finished;
    } obs_t;

    typedef struct {
        logic [2:0]  wstat;
        logic [63:0] wvalm;
        logic [3:0]  wdstm;
        logic        halt;
        int          stall_cnt;
        int          wait_cnt;
        logic        we;
        logic [63:0] addr;
    } exp_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] stat, input logic [3:0] icode,
                                  input logic [63:0] val_e, input logic [63:0] val_a,
                                  input logic [3:0] dst_e, input logic [3:0] dst_m);
        M_stat  = stat;
        M_icode = icode;
        M_cnd   = 1'b0;
        M_valE  = val_e;
        M_valA  = val_a;
        M_dstE  = dst_e;
        M_dstM  = dst_m;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        dmem.ack   = 1'b0;
        dmem.rdata = 64'd0;
        apply_stimulus(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Plays the memory side: acks after the request has been seen for
    // 'delay' full cycles, and records what the stage did meanwhile.
    task automatic mem_txn(input int delay, input logic [63:0] rdata, output obs_t o);
        logic done;
        o = '{0, 0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0};
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (halted) begin
                o.finished = 1'b1;
                break;
            end
            if (dmem.req) begin
                if (o.wait_cnt == 0) begin
                    o.we    = dmem.we;
                    o.addr  = dmem.addr;
                    o.wdata = dmem.wdata;
                end
                o.wait_cnt++;
                if (o.wait_cnt > delay) begin
                    dmem.ack   = 1'b1;
                    dmem.rdata = rdata;
                end
            end
            #1;
            if (m_stall) o.stall_cnt++;
            if (dmem.ack) o.valm = m_valM;
            done = !m_stall;
            step();
            dmem.ack   = 1'b0;
            dmem.rdata = 64'd0;
            if (done) begin
                o.finished = 1'b1;
                break;
            end
        end
        check("txn_bound", 64'(o.finished), 64'd1);
    endtask

    function automatic exp_t model(input logic [2:0] stat, input logic [3:0] icode,
                                   input logic [63:0] val_e, input logic [63:0] val_a,
                                   input logic [3:0] dst_m, input int delay,
                                   input logic [63:0] rdata);
        exp_t e;
        logic rdop, wrop;
        rdop   = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
        wrop   = (icode == 4'h4) || (icode == 4'h8) || (icode == 4'hA);
        e.addr = (icode == 4'h9 || icode == 4'hB) ? val_a : val_e;
        e.we   = wrop;
        e.wstat = stat;
        e.wvalm = 64'd0;
        e.wdstm = dst_m;
        e.halt  = 1'b0;
        e.stall_cnt = 0;
        e.wait_cnt  = 0;
        if (stat != 3'd1) begin
            e.halt = 1'b1;
        end else if (!(rdop || wrop)) begin
            e.halt = 1'b0;
        end else if (e.addr > 64'(MEM_BYTES - 8)) begin
            e.wstat = 3'd3;
            e.wdstm = 4'hF;
            e.halt  = 1'b1;
        end else if (delay >= TIMEOUT) begin
            e.wstat     = 3'd3;
            e.halt      = 1'b1;
            e.stall_cnt = 1 + TIMEOUT;
            e.wait_cnt  = TIMEOUT;
        end else begin
            e.stall_cnt = 1 + delay;
            e.wait_cnt  = delay + 1;
            if (rdop) e.wvalm = rdata;
        end
        return e;
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return 64'($urandom_range(0, MEM_BYTES - 8));
            1: return 64'(MEM_BYTES - 8);
            2: return 64'(MEM_BYTES - 7);
            3: return {$urandom, $urandom};
            default: return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
        endcase
    endfunction

    vec_t vecs[11];

    initial begin
        obs_t o;
        exp_t e;

        vecs[0]  = '{3'd1, 4'h6, 64'h2A,    64'h0,  4'h3, 4'hF, 1'b0, 3'd1, 3'd1, 4'hF, 1'b0};
        vecs[1]  = '{3'd1, 4'h3, 64'h1234,  64'h0,  4'h5, 4'hF, 1'b0, 3'd1, 3'd1, 4'hF, 1'b0};
        vecs[2]  = '{3'd1, 4'h1, 64'h0,     64'h0,  4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 4'hF, 1'b0};
        vecs[3]  = '{3'd1, 4'h7, 64'h40,    64'h44, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1, 4'hF, 1'b0};
        vecs[4]  = '{3'd1, 4'h4, 64'hFFC,   64'h77, 4'hF, 4'hF, 1'b0, 3'd3, 3'd3, 4'hF, 1'b1};
        vecs[5]  = '{3'd1, 4'h5, 64'hFF9,   64'h0,  4'hF, 4'h2, 1'b0, 3'd3, 3'd3, 4'hF, 1'b1};
        vecs[6]  = '{3'd1, 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'hF, 4'h4, 1'b0, 3'd3, 3'd3, 4'hF, 1'b1};
        vecs[7]  = '{3'd1, 4'hB, 64'h8,     64'h1000, 4'h4, 4'h6, 1'b0, 3'd3, 3'd3, 4'hF, 1'b1};
        vecs[8]  = '{3'd2, 4'h0, 64'h0,     64'h0,  4'hF, 4'hF, 1'b0, 3'd2, 3'd2, 4'hF, 1'b1};
        vecs[9]  = '{3'd4, 4'hC, 64'h5,     64'h0,  4'h1, 4'hF, 1'b0, 3'd4, 3'd4, 4'hF, 1'b1};
        vecs[10] = '{3'd3, 4'h5, 64'h100,   64'h0,  4'hF, 4'h3, 1'b0, 3'd3, 3'd3, 4'h3, 1'b1};

        do_reset();
        check("rst W_stat",  64'(W_stat),  64'd1);
        check("rst W_icode", 64'(W_icode), 64'd1);
        check("rst W_valE",  W_valE,       64'd0);
        check("rst W_valM",  W_valM,       64'd0);
        check("rst W_dstE",  64'(W_dstE),  64'hF);
        check("rst W_dstM",  64'(W_dstM),  64'hF);
        check("rst halted",  64'(halted),  64'd0);
        check("rst req",     64'(dmem.req), 64'd0);
        check("rst we",      64'(dmem.we),  64'd0);
        check("rst addr",    dmem.addr,    64'd0);
        check("rst wdata",   dmem.wdata,   64'd0);
        check("rst stall",   64'(m_stall), 64'd0);

        // single-cycle and immediately-halting cases
        foreach (vecs[i]) begin
            do_reset();
            apply_stimulus(vecs[i].stat, vecs[i].icode, vecs[i].val_e, vecs[i].val_a,
                           vecs[i].dst_e, vecs[i].dst_m);
            #1;
            check($sformatf("vec%0d m_stall", i), 64'(m_stall), 64'(vecs[i].exp_stall));
            check($sformatf("vec%0d m_stat", i),  64'(m_stat),  64'(vecs[i].exp_mstat));
            step();
            check($sformatf("vec%0d W_stat", i),  64'(W_stat),  64'(vecs[i].exp_wstat));
            check($sformatf("vec%0d W_icode", i), 64'(W_icode), 64'(vecs[i].icode));
            check($sformatf("vec%0d W_valE", i),  W_valE,       vecs[i].val_e);
            check($sformatf("vec%0d W_valM", i),  W_valM,       64'd0);
            check($sformatf("vec%0d W_dstE", i),  64'(W_dstE),  64'(vecs[i].dst_e));
            check($sformatf("vec%0d W_dstM", i),  64'(W_dstM),  64'(vecs[i].exp_wdstm));
            check($sformatf("vec%0d halted", i),  64'(halted),  64'(vecs[i].exp_halt));
            check($sformatf("vec%0d req", i),     64'(dmem.req), 64'd0);
        end

        // mrmovq with the ack three cycles after the request
        do_reset();
        apply_stimulus(3'd1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h2);
        mem_txn(3, 64'hDEADBEEF, o);
        check("ld stall_cnt", 64'(o.stall_cnt), 64'd4);
        check("ld wait_cnt",  64'(o.wait_cnt),  64'd4);
        check("ld we",        64'(o.we),        64'd0);
        check("ld addr",      o.addr,           64'h100);
        check("ld m_valM",    o.valm,           64'hDEADBEEF);
        check("ld W_valM",    W_valM,           64'hDEADBEEF);
        check("ld W_dstM",    64'(W_dstM),      64'h2);
        check("ld req after", 64'(dmem.req),    64'd0);

        // pushq at the last legal address, immediate ack
        do_reset();
        apply_stimulus(3'd1, 4'hA, 64'hFF8, 64'h55, 4'h4, 4'hF);
        mem_txn(0, 64'h1111, o);
        check("push stall_cnt", 64'(o.stall_cnt), 64'd1);
        check("push wait_cnt",  64'(o.wait_cnt),  64'd1);
        check("push we",        64'(o.we),        64'd1);
        check("push addr",      o.addr,           64'hFF8);
        check("push wdata",     o.wdata,          64'h55);
        check("push W_valM",    W_valM,           64'd0);
        check("push halted",    64'(halted),      64'd0);

        // popq whose ack lands in the last allowed WAIT cycle
        do_reset();
        apply_stimulus(3'd1, 4'hB, 64'h88, 64'h80, 4'h4, 4'h7);
        mem_txn(TIMEOUT - 1, 64'hABCD, o);
        check("late wait_cnt", 64'(o.wait_cnt), 64'(TIMEOUT));
        check("late W_stat",   64'(W_stat),     64'd1);
        check("late W_valM",   W_valM,          64'hABCD);
        check("late halted",   64'(halted),     64'd0);

        // popq that never gets an ack
        do_reset();
        apply_stimulus(3'd1, 4'hB, 64'h88, 64'h80, 4'h4, 4'h7);
        mem_txn(1000, 64'h0, o);
        check("to wait_cnt", 64'(o.wait_cnt), 64'(TIMEOUT));
        check("to W_stat",   64'(W_stat),     64'd3);
        check("to req",      64'(dmem.req),   64'd0);
        check("to halted",   64'(halted),     64'd1);

        // HALT ignores later instructions
        apply_stimulus(3'd1, 4'h6, 64'h2A, 64'h0, 4'h3, 4'hF);
        #1;
        check("halt stall", 64'(m_stall), 64'd1);
        step();
        step();
        check("halt W_stat",  64'(W_stat),   64'd3);
        check("halt W_icode", 64'(W_icode),  64'hB);
        check("halt req",     64'(dmem.req), 64'd0);
        check("halt halted",  64'(halted),   64'd1);

        // reset asserted in the middle of a call's WAIT
        do_reset();
        apply_stimulus(3'd1, 4'h6, 64'h2A, 64'h0, 4'h3, 4'hF);
        step();
        apply_stimulus(3'd1, 4'h8, 64'h200, 64'h1234, 4'h4, 4'hF);
        step();
        check("call req", 64'(dmem.req), 64'd1);
        check("call we",  64'(dmem.we),  64'd1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst req",    64'(dmem.req), 64'd0);
        check("midrst W_stat", 64'(W_stat),   64'd1);
        check("midrst W_icode",64'(W_icode),  64'd1);
        check("midrst W_valE", W_valE,        64'd0);
        check("midrst W_dstE", 64'(W_dstE),   64'hF);
        check("midrst W_dstM", 64'(W_dstM),   64'hF);
        #1;
        apply_stimulus(3'd1, 4'h1, 64'h99, 64'h0, 4'hF, 4'hF);
        rst_n = 1'b1;
        step();
        check("post nop W_valE", W_valE,        64'h99);
        check("post nop W_icode",64'(W_icode),  64'd1);
        check("post nop req",    64'(dmem.req), 64'd0);
        check("post nop stall",  64'(m_stall),  64'd0);

        // randomized transactions against the rule-level model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  st;
            logic [3:0]  ic, de, dm;
            logic [63:0] ve, va, rdv;
            int          dly;
            if (halted) do_reset();
            st  = ($urandom_range(0, 9) < 8) ? 3'd1 : 3'($urandom_range(2, 4));
            ic  = 4'($urandom_range(0, 11));
            ve  = rand_addr();
            va  = rand_addr();
            de  = 4'($urandom);
            dm  = 4'($urandom);
            rdv = {$urandom, $urandom};
            dly = $urandom_range(0, 20);
            e   = model(st, ic, ve, va, dm, dly, rdv);
            apply_stimulus(st, ic, ve, va, de, dm);
            mem_txn(dly, rdv, o);
            check($sformatf("rnd%0d stall_cnt", n), 64'(o.stall_cnt), 64'(e.stall_cnt));
            check($sformatf("rnd%0d wait_cnt", n),  64'(o.wait_cnt),  64'(e.wait_cnt));
            if (e.wait_cnt > 0) begin
                check($sformatf("rnd%0d we", n),    64'(o.we), 64'(e.we));
                check($sformatf("rnd%0d addr", n),  o.addr,    e.addr);
                check($sformatf("rnd%0d wdata", n), o.wdata,   va);
            end
            check($sformatf("rnd%0d W_stat", n),  64'(W_stat),  64'(e.wstat));
            check($sformatf("rnd%0d W_icode", n), 64'(W_icode), 64'(ic));
            check($sformatf("rnd%0d W_valE", n),  W_valE,       ve);
            check($sformatf("rnd%0d W_valM", n),  W_valM,       e.wvalm);
            check($sformatf("rnd%0d W_dstE", n),  64'(W_dstE),  64'(de));
            check($sformatf("rnd%0d W_dstM", n),  64'(W_dstM),  64'(e.wdstm));
            check($sformatf("rnd%0d halted", n),  64'(halted),  64'(e.halt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
